// File: rtl/adc_pkg.sv
// Shared types and default timing for the serial SAR ADC emulator.
package adc_pkg;

  localparam int ADC_BITS = 18;

  // Default timing; the controller derives its T2 (CNVST to BUSY) and
  // T9 (conversion time) waits from the same values.
  localparam int T_CONV_DELAY        = 2;
  localparam int T_BUSY_CYCLES       = 60;
  localparam int T_RESET_BUSY_CYCLES = 20;

  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_RST_BUSY,
    ST_IDLE,
    ST_CONV_DLY,
    ST_CONV_BUSY,
    ST_DATA
  } adc_state_t;

  // Internal visibility for checkers: FSM state, trigger arm, bit counter
  // and the registered pin edges {sclk, cnvst, cs}.
  typedef struct packed {
    adc_state_t  state;
    logic        armed;
    logic [4:0]  bitcnt;
    logic [2:0]  fall;
    logic [2:0]  rise;
  } adc_dbg_t;

  // Offset binary is two's complement with the MSB inverted.
  function automatic logic [ADC_BITS-1:0] apply_ob2c(input logic [ADC_BITS-1:0] raw,
                                                     input logic ob2c);
    return {raw[ADC_BITS-1] ^ ob2c, raw[ADC_BITS-2:0]};
  endfunction

endpackage

// File: rtl/adc_serial_emulator_if.sv
// Pin bundle between the ADC controller (master) and the ADC (slave).
// Pin semantics: CNVST/CS active-low, SCLK idles high and the controller
// samples SDOUT in the cycle it drives SCLK low; BUSY high means no data is
// available; RDERROR is sticky until the RESET pin is pulsed.
interface adc_serial_emulator_if;
  logic SCLK;
  logic CNVST;
  logic CS;
  logic RESET;
  logic OB2C;
  logic PD;
  logic SDOUT;
  logic BUSY;
  logic RDERROR;

  modport master (output SCLK, CNVST, CS, RESET, OB2C, PD,
                  input  SDOUT, BUSY, RDERROR);
  modport slave  (input  SCLK, CNVST, CS, RESET, OB2C, PD,
                  output SDOUT, BUSY, RDERROR);
endinterface

// File: rtl/adc_serial_emulator_edge_detect.sv
// Registered edge detector for a pin that is synchronous to clk.
module adc_edge_detect #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic fall,
  output logic rise
);

  logic pin_q;

  // Previous-cycle pin value; reset to the pin's idle level so no edge fires.
  always_ff @(posedge clk) begin
    if (reset) pin_q <= RESET_LEVEL;
    else       pin_q <= pin;
  end

  assign fall = pin_q & ~pin;
  assign rise = ~pin_q & pin;

endmodule

// File: rtl/adc_serial_emulator.sv
// Pin-level emulation of the 18-bit serial SAR ADC for the loopback build.
module adc_serial_emulator
  import adc_pkg::*;
#(
  parameter int CONV_DELAY         = T_CONV_DELAY,
  parameter int BUSY_CYCLES        = T_BUSY_CYCLES,
  parameter int RESET_BUSY_CYCLES  = T_RESET_BUSY_CYCLES,
  parameter bit RETRIGGER_ON_LEVEL = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  adc_serial_emulator_if.slave bus,
  input  logic [ADC_BITS-1:0] sample_in,
  input  logic                use_counter,
  input  logic                inject_rderror,
  output logic [15:0]         conv_count,
  output adc_dbg_t            dbg
);

  localparam logic [15:0] DLY_LAST  = 16'(CONV_DELAY - 1);
  localparam logic [15:0] BUSY_LAST = 16'(BUSY_CYCLES - 1);
  localparam logic [15:0] RST_LAST  = 16'(RESET_BUSY_CYCLES - 1);
  localparam logic [4:0]  BITS      = 5'(ADC_BITS);

  adc_state_t          state, state_n;
  logic [15:0]         tmr;
  logic [ADC_BITS-1:0] shreg, ramp;
  logic [4:0]          bitcnt;
  logic                armed, rderror;
  logic                trig, conv_done, stray_sclk;
  logic                sclk_fall, sclk_rise, cnvst_fall, cnvst_rise, cs_fall, cs_rise;

  adc_edge_detect #(.RESET_LEVEL(1'b1)) u_sclk_edge (
    .clk(clk), .reset(reset), .pin(bus.SCLK), .fall(sclk_fall), .rise(sclk_rise));
  adc_edge_detect #(.RESET_LEVEL(1'b1)) u_cnvst_edge (
    .clk(clk), .reset(reset), .pin(bus.CNVST), .fall(cnvst_fall), .rise(cnvst_rise));
  adc_edge_detect #(.RESET_LEVEL(1'b1)) u_cs_edge (
    .clk(clk), .reset(reset), .pin(bus.CS), .fall(cs_fall), .rise(cs_rise));

  // A conversion may only start from IDLE or DATA; PD and the RESET pin block it.
  assign trig = (state == ST_IDLE || state == ST_DATA) && !bus.RESET && !bus.PD &&
                armed && !bus.CNVST && (cnvst_fall || RETRIGGER_ON_LEVEL);

  // Clocking SCLK while the ADC has no data to shift out is a read error.
  assign stray_sclk = sclk_fall && !bus.CS &&
                      (state inside {ST_CONV_DLY, ST_CONV_BUSY, ST_RST_HOLD, ST_RST_BUSY});

  // Next-state decode; the RESET pin overrides every other transition.
  always_comb begin
    state_n   = state;
    conv_done = 1'b0;
    case (state)
      ST_RST_HOLD:  state_n = ST_RST_BUSY;
      ST_RST_BUSY:  if (tmr == RST_LAST) state_n = ST_IDLE;
      ST_IDLE,
      ST_DATA:      if (trig) state_n = ST_CONV_DLY;
      ST_CONV_DLY:  if (tmr == DLY_LAST) state_n = ST_CONV_BUSY;
      ST_CONV_BUSY: if (tmr == BUSY_LAST) begin
                      state_n   = ST_DATA;
                      conv_done = 1'b1;
                    end
      default:      state_n = ST_IDLE;
    endcase
    if (bus.RESET) begin
      state_n   = ST_RST_HOLD;
      conv_done = 1'b0;
    end
  end

  // State register plus a dwell timer that restarts on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_n;
      tmr   <= (state_n != state) ? 16'd0 : tmr + 16'd1;
    end
  end

  // Sample capture, serial shift, counters, trigger arm and read-error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      ramp       <= '0;
      conv_count <= '0;
      bitcnt     <= '0;
      armed      <= 1'b1;
      rderror    <= 1'b0;
    end else if (bus.RESET) begin
      shreg   <= '0;
      bitcnt  <= '0;
      armed   <= 1'b1;
      rderror <= 1'b0;
    end else begin
      if (trig) begin
        shreg <= apply_ob2c(use_counter ? ramp : sample_in, bus.OB2C);
        ramp  <= ramp + 1'b1;
        armed <= 1'b0;
        if (state == ST_DATA && bitcnt != 5'd0 && bitcnt < BITS) rderror <= 1'b1;
      end else if (cnvst_rise || (RETRIGGER_ON_LEVEL && cs_rise)) begin
        armed <= 1'b1;
      end

      if (conv_done) begin
        bitcnt     <= '0;
        conv_count <= conv_count + 16'd1;
      end else if (cs_rise) begin
        bitcnt <= '0;
      end else if (state == ST_DATA && !trig && sclk_fall && !bus.CS) begin
        shreg <= {shreg[ADC_BITS-2:0], 1'b0};
        if (bitcnt <= BITS) bitcnt <= bitcnt + 5'd1;
        if (bitcnt >= BITS) rderror <= 1'b1;
      end

      if (stray_sclk || inject_rderror) rderror <= 1'b1;
    end
  end

  assign bus.BUSY    = (state == ST_RST_BUSY) || (state == ST_CONV_BUSY);
  assign bus.SDOUT   = (!bus.CS && state == ST_DATA && !bus.PD) ? shreg[ADC_BITS-1] : 1'b0;
  assign bus.RDERROR = rderror;

  assign dbg.state  = state;
  assign dbg.armed  = armed;
  assign dbg.bitcnt = bitcnt;
  assign dbg.fall   = {sclk_fall, cnvst_fall, cs_fall};
  assign dbg.rise   = {sclk_rise, cnvst_rise, cs_rise};

endmodule

// File: tb/tb_adc_serial_emulator.sv
// Directed + randomized bench for adc_serial_emulator with a word-level model.
module tb_adc_serial_emulator;
  import adc_pkg::*;

  localparam int EXP_RISE     = 3;   // CNVST drive -> BUSY: 1 sync cycle + CONV_DELAY
  localparam int EXP_BUSY     = 60;
  localparam int EXP_RST_RISE = 1;
  localparam int EXP_RST_BUSY = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #4 clk = ~clk;

  logic [17:0] sample_in;
  logic        use_counter;
  logic        inject_rderror;
  logic [15:0] conv_count;
  adc_dbg_t    dbg;

  adc_serial_emulator_if bus ();

  adc_serial_emulator dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .sample_in(sample_in),
    .use_counter(use_counter),
    .inject_rderror(inject_rderror),
    .conv_count(conv_count),
    .dbg(dbg)
  );

  // ---------------- scoreboard / model ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [17:0] exp_q[$];
  logic [17:0] ramp_m;
  logic [15:0] count_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offset binary = two's complement plus half of full scale, modulo 2^18.
  function automatic logic [17:0] ref_word(input logic [17:0] raw, input logic ob2c);
    logic [17:0] half;
    half = ob2c ? 18'd131072 : 18'd0;
    return raw + half;
  endfunction

  task automatic note_trigger();
    exp_q.push_back(ref_word(use_counter ? ramp_m : sample_in, bus.OB2C));
    ramp_m = ramp_m + 18'd1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_busy(input logic lvl, input int limit, output int n);
    n = 0;
    while (bus.BUSY !== lvl && n < limit) begin
      tick();
      n++;
    end
    if (bus.BUSY !== lvl) n = -1;
  endtask

  task automatic read_word(input int nbits, output logic [17:0] w);
    w = '0;
    bus.CS = 1'b0;
    tick();
    for (int i = 0; i < nbits; i++) begin
      bus.SCLK = 1'b0;
      @(negedge clk);
      if (i < 18) w = {w[16:0], bus.SDOUT};
      tick();
      bus.SCLK = 1'b1;
      tick();
    end
    bus.CS = 1'b1;
    tick();
  endtask

  task automatic read_and_check(input string tag);
    logic [17:0] w;
    logic [17:0] e;
    read_word(18, w);
    check({tag, "_depth"}, exp_q.size(), 1);
    e = exp_q.pop_front();
    check(tag, w, e);
  endtask

  task automatic conv(input logic [17:0] s, input logic ob, input logic uc);
    int lat, hi;
    sample_in   = s;
    bus.OB2C    = ob;
    use_counter = uc;
    bus.CNVST   = 1'b0;
    note_trigger();
    wait_busy(1'b1, 10, lat);
    check("busy_latency", lat, EXP_RISE);
    wait_busy(1'b0, 200, hi);
    check("busy_width", hi, EXP_BUSY);
    bus.CNVST = 1'b1;
    count_m   = count_m + 16'd1;
    check("conv_count", conv_count, count_m);
    tick();
  endtask

  task automatic sclk_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      bus.SCLK = 1'b0;
      tick();
      bus.SCLK = 1'b1;
      tick();
    end
  endtask

  task automatic reset_pin();
    int lat, hi;
    bus.RESET = 1'b1;
    tick(); tick(); tick();
    check("rst_hold_busy", bus.BUSY, 0);
    check("rst_hold_state", dbg.state, ST_RST_HOLD);
    bus.RESET = 1'b0;
    wait_busy(1'b1, 5, lat);
    check("rst_busy_latency", lat, EXP_RST_RISE);
    wait_busy(1'b0, 100, hi);
    check("rst_busy_width", hi, EXP_RST_BUSY);
    check("rst_rderror", bus.RDERROR, 0);
    check("rst_state", dbg.state, ST_IDLE);
    exp_q.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat, hi;
    logic [17:0] w;
    logic [17:0] e;

    bus.SCLK = 1'b1; bus.CNVST = 1'b1; bus.CS = 1'b1; bus.RESET = 1'b0;
    bus.OB2C = 1'b0; bus.PD = 1'b0;
    sample_in = '0; use_counter = 1'b0; inject_rderror = 1'b0;
    ramp_m = '0; count_m = '0;
    reset = 1'b1;
    tick(); tick();

    // Reset state
    check("reset_state", dbg.state, ST_IDLE);
    check("reset_busy", bus.BUSY, 0);
    check("reset_sdout", bus.SDOUT, 0);
    check("reset_rderror", bus.RDERROR, 0);
    check("reset_conv_count", conv_count, 0);
    reset = 1'b0;
    tick();

    // RESET pin: BUSY for 20 cycles after release
    reset_pin();

    // Two's complement and offset binary captures of a fixed sample
    conv(18'h2A5A3, 1'b0, 1'b0);
    read_and_check("word_twos");
    check("read18_rderror", bus.RDERROR, 0);
    conv(18'h2A5A3, 1'b1, 1'b0);
    read_and_check("word_offset");

    // Randomized conversions against the model
    for (int i = 0; i < 5; i++) begin
      conv(18'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      read_and_check("rand_word");
    end

    // Power-down: CNVST ignored in DATA, SDOUT forced low
    conv(18'h3FFFF, 1'b0, 1'b0);
    bus.PD = 1'b1;
    bus.CNVST = 1'b0;
    repeat (6) tick();
    check("pd_no_busy", bus.BUSY, 0);
    check("pd_state", dbg.state, ST_DATA);
    bus.CS = 1'b0;
    tick();
    check("pd_sdout", bus.SDOUT, 0);
    bus.CNVST = 1'b1;
    tick();
    bus.PD = 1'b0;
    bus.CS = 1'b1;
    tick();
    read_and_check("pd_word");

    // 19th SCLK fall sets a sticky RDERROR
    conv(18'($urandom()), 1'b0, 1'b0);
    read_word(19, w);
    e = exp_q.pop_front();
    check("read19_word", w, e);
    check("read19_rderror", bus.RDERROR, 1);
    conv(18'($urandom()), 1'b0, 1'b0);
    read_and_check("sticky_word");
    check("rderror_sticky", bus.RDERROR, 1);
    reset_pin();

    // SCLK toggling with CS low while BUSY
    sample_in = 18'($urandom());
    bus.CNVST = 1'b0;
    note_trigger();
    wait_busy(1'b1, 10, lat);
    check("stray_busy_latency", lat, EXP_RISE);
    bus.CNVST = 1'b1;
    bus.CS = 1'b0;
    tick();
    sclk_pulses(2);
    bus.CS = 1'b1;
    tick();
    check("stray_rderror", bus.RDERROR, 1);
    wait_busy(1'b0, 200, hi);
    count_m = count_m + 16'd1;
    check("stray_conv_count", conv_count, count_m);
    read_and_check("stray_word");
    reset_pin();

    // Injected read error
    inject_rderror = 1'b1;
    tick();
    inject_rderror = 1'b0;
    check("inject_rderror", bus.RDERROR, 1);
    reset_pin();

    // Retrigger during a partial readout
    conv(18'($urandom()), 1'($urandom_range(0, 1)), 1'b0);
    bus.CS = 1'b0;
    tick();
    sclk_pulses(7);
    void'(exp_q.pop_front());
    bus.CNVST = 1'b0;
    note_trigger();
    tick();
    check("partial_state", dbg.state, ST_CONV_DLY);
    check("partial_rderror", bus.RDERROR, 1);
    bus.CNVST = 1'b1;
    bus.CS = 1'b1;
    wait_busy(1'b1, 10, lat);
    wait_busy(1'b0, 200, hi);
    count_m = count_m + 16'd1;
    check("partial_conv_count", conv_count, count_m);
    read_and_check("partial_new_word");
    reset_pin();

    // Synchronous reset in the middle of a readout
    conv(18'h3FFFF, 1'b0, 1'b0);
    bus.CS = 1'b0;
    tick();
    sclk_pulses(7);
    reset = 1'b1;
    tick();
    check("midread_busy", bus.BUSY, 0);
    check("midread_sdout", bus.SDOUT, 0);
    check("midread_state", dbg.state, ST_IDLE);
    check("midread_conv_count", conv_count, 0);
    reset = 1'b0;
    bus.CS = 1'b1;
    tick();
    ramp_m = '0;
    count_m = '0;
    exp_q.delete();

    // Ramp source with CNVST held low: CS rise re-arms the trigger
    use_counter = 1'b1;
    bus.OB2C = 1'b0;
    bus.CNVST = 1'b0;
    note_trigger();
    for (int k = 0; k < 3; k++) begin
      wait_busy(1'b1, 10, lat);
      check("level_latency", lat, EXP_RISE);
      wait_busy(1'b0, 200, hi);
      check("level_width", hi, EXP_BUSY);
      count_m = count_m + 16'd1;
      check("level_conv_count", conv_count, count_m);
      read_and_check("level_ramp_word");
      if (k == 2) bus.CNVST = 1'b1;
      else note_trigger();
    end
    repeat (5) tick();
    check("level_stop_state", dbg.state, ST_DATA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_serial_emulator.md
Name: adc_serial_emulator

Overview:
Synthesizable model of the 18-bit serial SAR ADC, seen from the ADC pin side. It responds to CNVST/CS/SCLK/RESET from the ADC controller and drives BUSY, SDOUT and RDERROR. It sits in the loopback test build in place of the physical ADC, so the acquisition path can be exercised on the FPGA without the converter. All pin inputs are synchronous to clk, because the controller runs in the same domain.

Parameters:
CONV_DELAY, 2, cycles from CNVST trigger detection to BUSY rise (>=1)
BUSY_CYCLES, 60, conversion BUSY high time in cycles (480 ns at 125 MHz)
RESET_BUSY_CYCLES, 20, BUSY high time after the RESET pin is released
RETRIGGER_ON_LEVEL, 1, 1: a completed readout (CS rising) re-arms the trigger even if CNVST stayed low; 0: CNVST must return high

Ports:
clk  in  1  system clock, 125 MHz
reset  in  1  synchronous, active-high
SCLK  in  1  serial clock from controller, idle high
CNVST  in  1  conversion start, active-low
CS  in  1  chip select, active-low
RESET  in  1  ADC reset pin, active-high
OB2C  in  1  0: two's complement out; 1: offset binary (MSB inverted)
PD  in  1  power-down, active-high
sample_in  in  18  value converted when use_counter=0, two's complement
use_counter  in  1  1: convert the internal 18-bit ramp counter instead of sample_in
inject_rderror  in  1  one-cycle pulse sets RDERROR
SDOUT  out  1  serial data, MSB first
BUSY  out  1  conversion / reset in progress
RDERROR  out  1  sticky read error
conv_count  out  16  completed conversions, wraps at 0xFFFF

Behaviour:
- Edge detection: registers sclk_q, cnvst_q, cs_q sample the pins each cycle. A fall is q=1 and pin=0; a rise is the reverse. Reset values are sclk_q=1, cnvst_q=1, cs_q=1.
- Reset (clk domain): state=IDLE, BUSY=0, SDOUT=0, RDERROR=0, shreg=0, ramp=0, conv_count=0, bitcnt=0, armed=1. Reset wins over every other event, including mid-conversion or mid-readout.
- States: RST_HOLD, RST_BUSY, IDLE, CONV_DLY, CONV_BUSY, DATA.
- RESET pin high, any state: go to RST_HOLD, BUSY=0, clear RDERROR and shreg, armed=1. On RESET fall: RST_BUSY with BUSY=1 for RESET_BUSY_CYCLES cycles, then IDLE.
- PD=1: CNVST is ignored in IDLE/DATA, and SDOUT is forced to 0. A conversion in progress still completes.
- Trigger: in IDLE or DATA, when armed=1, CNVST=0 and (CNVST fall or RETRIGGER_ON_LEVEL):
  - latch the source into shreg. The source is ramp if use_counter, else sample_in. MSB is inverted when OB2C=1.
  - ramp increments; armed=0; go to CONV_DLY.
- Rearm: armed=1 on a CNVST rise, or on a CS rise when RETRIGGER_ON_LEVEL=1.
- Trigger in DATA with bitcnt in 1..17 (partial readout) sets RDERROR.
- CONV_DLY: after CONV_DELAY cycles go to CONV_BUSY, BUSY=1 for BUSY_CYCLES cycles. Then BUSY=0, go to DATA, bitcnt=0, conv_count+1.
- SDOUT is combinational: shreg[17] when CS=0, state=DATA and PD=0; else 0.
- Readout timing: bit 17 is valid from CS fall. On each SCLK fall with CS=0 in DATA, shreg shifts left (zero fill) and bitcnt increments. The controller samples on the cycle it sees SCLK=0, which is the same edge as the shift, so it captures the pre-shift bit.
- RDERROR (sticky until reset or RESET pin) is set by any of:
  - an SCLK fall with CS=0 in CONV_DLY/CONV_BUSY/RST_*;
  - a 19th SCLK fall in one readout;
  - inject_rderror.
- CS rise resets bitcnt=0. Shreg is kept, so a re-read restarts only after a new conversion.
- Counters are saturate-free and wrap modulo 2^18 (ramp) or 2^16 (conv_count).

Decomposition:
- Package adc_pkg holds:
  - the state enum;
  - ADC_BITS=18;
  - default timing constants, shared with the controller's T2/T9 values.
- One sub-module, adc_edge_detect: registered fall/rise detector with parameterised reset level, instantiated for SCLK, CNVST and CS.

Test Plan:
- RESET pin high 3 cycles then low → BUSY rises the next cycle and stays high exactly 20 cycles; RDERROR=0.
- sample_in=18'h2A5A3, OB2C=0, CNVST fall → BUSY rises 2 cycles later, high 60 cycles. After CS low and 18 SCLK falls, the captured word is 0x2A5A3; conv_count=1.
- Same with OB2C=1 → captured 0x0A5A3.
- use_counter=1, three conversions with CNVST held low (RETRIGGER_ON_LEVEL=1) → captured words 0, 1, 2.
- A 19th SCLK fall, or SCLK toggling while BUSY=1 → RDERROR=1 and stays 1 until the RESET pin is pulsed.
- Synchronous reset asserted mid-readout after 7 bits → next cycle BUSY=0, SDOUT=0, state IDLE, conv_count=0.
